// File: rtl/tb_run_pkg.sv
// Shared types and constants for the run controller: FSM states, run
// status codes and the instruction that ends a run (RISC-V ecall).
package tb_run_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        HALT    = 2'd1,
        TIMEOUT = 2'd2,
        STALL   = 2'd3
    } status_e;

    localparam logic [31:0] HALT_INSN = 32'h0000_0073;

    // True when a valid fetched instruction is the halt instruction.
    function automatic logic is_halt(input logic valid, input logic [31:0] insn);
        return valid && (insn == HALT_INSN);
    endfunction

endpackage

// File: rtl/tb_run_ctrl_stall_detector.sv
// Watches the fetch PC during a run and flags a stall when the PC has been
// repeated STALL_LIMIT consecutive cycles. The first enabled cycle after a
// clear only records the PC, so it never counts as a repeat.
module stall_detector #(
    parameter int AWIDTH      = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [AWIDTH-1:0] pc_i,
    output logic              stall_o
);

    localparam int            LW       = $clog2(STALL_LIMIT);
    localparam logic [LW-1:0] LEN_LAST = LW'(STALL_LIMIT - 1);
    localparam logic [LW-1:0] LEN_ONE  = LW'(1);

    logic [AWIDTH-1:0] prev_pc_q, prev_pc_d;
    logic              have_prev_q, have_prev_d;
    logic [LW-1:0]     run_len_q, run_len_d;
    logic              same_s;

    // A repeat needs a recorded previous PC to compare against.
    assign same_s  = have_prev_q && (pc_i == prev_pc_q);
    // run_len_q counts repeats already seen; this cycle's repeat is the last one.
    assign stall_o = en_i && same_s && (run_len_q == LEN_LAST);

    // Next-state of the previous-PC register and repeat counter.
    always_comb begin
        prev_pc_d   = prev_pc_q;
        have_prev_d = have_prev_q;
        run_len_d   = run_len_q;
        if (clr_i) begin
            prev_pc_d   = {AWIDTH{1'b0}};
            have_prev_d = 1'b0;
            run_len_d   = {LW{1'b0}};
        end else if (en_i) begin
            prev_pc_d   = pc_i;
            have_prev_d = 1'b1;
            if (same_s) begin
                if (run_len_q == LEN_LAST) begin
                    run_len_d = run_len_q;
                end else begin
                    run_len_d = run_len_q + LEN_ONE;
                end
            end else begin
                run_len_d = {LW{1'b0}};
            end
        end else begin
            run_len_d = run_len_q;
        end
    end

    // Stall-tracking state, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pc_q   <= {AWIDTH{1'b0}};
            have_prev_q <= 1'b0;
            run_len_q   <= {LW{1'b0}};
        end else begin
            prev_pc_q   <= prev_pc_d;
            have_prev_q <= have_prev_d;
            run_len_q   <= run_len_d;
        end
    end

endmodule

// File: rtl/tb_run_ctrl.sv
// Run controller for a core under test: holds the core in reset for a fixed
// number of clocks, lets it run while counting cycles and instructions, and
// ends the run on halt, stall or timeout. A restart pulse in DONE re-arms it.
module tb_run_ctrl
    import tb_run_pkg::*;
#(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 1000,
    parameter int STALL_LIMIT  = 16,
    parameter int CWIDTH       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic [AWIDTH-1:0] pc,
    input  logic [DWIDTH-1:0] insn,
    input  logic              insn_valid,
    output logic              core_reset,
    output logic              running,
    output logic              done,
    output logic [1:0]        status,
    output logic [CWIDTH-1:0] cycle_count,
    output logic [CWIDTH-1:0] insn_count
);

    localparam int                HW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0]     HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [HW-1:0]     HOLD_ONE  = HW'(1);
    localparam logic [CWIDTH-1:0] CYC_LAST  = CWIDTH'(MAX_CYCLES - 1);
    localparam logic [CWIDTH-1:0] CNT_ONE   = CWIDTH'(1);

    state_e            state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    status_e           status_q, status_d;
    logic [CWIDTH-1:0] cyc_q, cyc_d;
    logic [CWIDTH-1:0] insn_q, insn_d;

    logic halt_s;
    logic stall_s;
    logic timeout_s;
    logic det_en_s;
    logic det_clr_s;

    // Halt detection widens the instruction to 32 bits for comparison.
    assign halt_s    = is_halt(insn_valid, 32'(insn));
    assign timeout_s = (cyc_q == CYC_LAST);
    assign det_en_s  = (state_q == RUN);
    // The detector is wiped during every HOLD so each run starts with no previous PC.
    assign det_clr_s = (state_q == HOLD);

    stall_detector #(
        .AWIDTH     (AWIDTH),
        .STALL_LIMIT(STALL_LIMIT)
    ) u_stall (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (det_clr_s),
        .en_i   (det_en_s),
        .pc_i   (pc),
        .stall_o(stall_s)
    );

    // FSM next-state, hold counter, run counters and end-of-run status.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        status_d = status_q;
        cyc_d    = cyc_q;
        insn_d   = insn_q;
        case (state_q)
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                    hold_d  = {HW{1'b0}};
                end else begin
                    hold_d  = hold_q + HOLD_ONE;
                end
            end
            RUN: begin
                cyc_d = cyc_q + CNT_ONE;
                if (insn_valid) begin
                    insn_d = insn_q + CNT_ONE;
                end else begin
                    insn_d = insn_q;
                end
                // Halt outranks stall, which outranks timeout.
                if (halt_s) begin
                    state_d  = DONE;
                    status_d = HALT;
                end else if (stall_s) begin
                    state_d  = DONE;
                    status_d = STALL;
                end else if (timeout_s) begin
                    state_d  = DONE;
                    status_d = TIMEOUT;
                end else begin
                    state_d  = RUN;
                end
            end
            DONE: begin
                if (restart) begin
                    state_d  = HOLD;
                    hold_d   = {HW{1'b0}};
                    status_d = NONE;
                    cyc_d    = {CWIDTH{1'b0}};
                    insn_d   = {CWIDTH{1'b0}};
                end else begin
                    state_d  = DONE;
                end
            end
            default: begin
                state_d  = HOLD;
                hold_d   = {HW{1'b0}};
                status_d = NONE;
                cyc_d    = {CWIDTH{1'b0}};
                insn_d   = {CWIDTH{1'b0}};
            end
        endcase
    end

    // Controller state; reset forces HOLD with everything cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= HOLD;
            hold_q   <= {HW{1'b0}};
            status_q <= NONE;
            cyc_q    <= {CWIDTH{1'b0}};
            insn_q   <= {CWIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            status_q <= status_d;
            cyc_q    <= cyc_d;
            insn_q   <= insn_d;
        end
    end

    // Outputs come straight from registers or from the state decode.
    assign core_reset  = (state_q != RUN);
    assign running     = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign status      = status_q;
    assign cycle_count = cyc_q;
    assign insn_count  = insn_q;

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Directed bench for tb_run_ctrl: a per-cycle vector table for reset release,
// a halting run, DONE freeze and restart, followed by hand-written sequences
// for stall, timeout, simultaneous terminations and asynchronous reset.
module tb_tb_run_ctrl;
    import tb_run_pkg::*;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        insn_valid;
    logic        core_reset;
    logic        running;
    logic        done;
    logic [1:0]  status;
    logic [31:0] cycle_count;
    logic [31:0] insn_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        r;
        logic [31:0] p;
        logic [31:0] i;
        logic        v;
        logic        e_cr;
        logic        e_run;
        logic        e_done;
        logic [1:0]  e_st;
        logic [31:0] e_cyc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t tbl[$];

    tb_run_ctrl #(
        .AWIDTH      (32),
        .DWIDTH      (32),
        .RESET_CYCLES(2),
        .MAX_CYCLES  (50),
        .STALL_LIMIT (16),
        .CWIDTH      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .pc         (pc),
        .insn       (insn),
        .insn_valid (insn_valid),
        .core_reset (core_reset),
        .running    (running),
        .done       (done),
        .status     (status),
        .cycle_count(cycle_count),
        .insn_count (insn_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [31:0] p, input logic [31:0] i,
                                input logic v, input logic cr, input logic run,
                                input logic dn, input logic [1:0] st,
                                input logic [31:0] cyc, input logic [31:0] ins);
        vec_t t;
        t.r = r; t.p = p; t.i = i; t.v = v;
        t.e_cr = cr; t.e_run = run; t.e_done = dn; t.e_st = st;
        t.e_cyc = cyc; t.e_ins = ins;
        return t;
    endfunction

    task automatic check(input string name, input logic e_cr, input logic e_run,
                         input logic e_done, input logic [1:0] e_st,
                         input logic [31:0] e_cyc, input logic [31:0] e_ins);
        logic [68:0] act;
        logic [68:0] exp;
        act = {core_reset, running, done, status, cycle_count, insn_count};
        exp = {e_cr, e_run, e_done, e_st, e_cyc, e_ins};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got cr=%0b run=%0b done=%0b st=%0d cyc=%0d insn=%0d, want cr=%0b run=%0b done=%0b st=%0d cyc=%0d insn=%0d",
                     name, core_reset, running, done, status, cycle_count, insn_count,
                     e_cr, e_run, e_done, e_st, e_cyc, e_ins);
        end
    endtask

    task automatic check_hold(input string name);
        check(name, 1'b1, 1'b0, 1'b0, NONE, 32'd0, 32'd0);
    endtask

    task automatic check_run(input string name, input logic [31:0] cyc, input logic [31:0] ins);
        check(name, 1'b0, 1'b1, 1'b0, NONE, cyc, ins);
    endtask

    task automatic check_done(input string name, input logic [1:0] st,
                              input logic [31:0] cyc, input logic [31:0] ins);
        check(name, 1'b1, 1'b0, 1'b1, st, cyc, ins);
    endtask

    task automatic drive(input logic r, input logic [31:0] p, input logic [31:0] i, input logic v);
        restart    = r;
        pc         = p;
        insn       = i;
        insn_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From DONE: restart pulse, two HOLD clocks (with restart/ecall ignored), then RUN.
    task automatic restart_to_run(input string tag);
        drive(1'b1, 32'h0, NOP, 1'b0);
        tick();
        check_hold({tag, "_restart_hold"});
        drive(1'b1, 32'h0, ECALL, 1'b1);
        tick();
        check_hold({tag, "_hold2"});
        drive(1'b0, 32'h0, NOP, 1'b0);
        tick();
        check_run({tag, "_run_start"}, 32'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        reset = 1'b1;
        drive(1'b0, 32'h0, NOP, 1'b0);
        #2 reset = 1'b0;
        #10;
        check_hold("reset_state");
        @(posedge clk);
        #1 reset = 1'b1;

        // Reset release: restart and ecall are ignored in HOLD; RUN after two edges.
        tbl.push_back(mk(1'b1, 32'h0, ECALL, 1'b1, 1'b1, 1'b0, 1'b0, NONE, 32'd0, 32'd0));
        tbl.push_back(mk(1'b1, 32'h0, ECALL, 1'b1, 1'b0, 1'b1, 1'b0, NONE, 32'd0, 32'd0));
        // Ten-cycle run ending in ecall; restart in cycle 5 is ignored.
        for (int k = 1; k <= 10; k++) begin
            if (k < 10)
                tbl.push_back(mk((k == 5), 32'h1000 + 32'(4 * (k - 1)), NOP, 1'b1,
                                 1'b0, 1'b1, 1'b0, NONE, 32'(k), 32'(k)));
            else
                tbl.push_back(mk(1'b0, 32'h1000 + 32'(4 * (k - 1)), ECALL, 1'b1,
                                 1'b1, 1'b0, 1'b1, HALT, 32'd10, 32'd10));
        end
        // DONE freezes status and counters.
        tbl.push_back(mk(1'b0, 32'h5000, NOP, 1'b1, 1'b1, 1'b0, 1'b1, HALT, 32'd10, 32'd10));
        tbl.push_back(mk(1'b0, 32'h5004, ECALL, 1'b1, 1'b1, 1'b0, 1'b1, HALT, 32'd10, 32'd10));
        // Restart clears everything and re-enters HOLD for two clocks.
        tbl.push_back(mk(1'b1, 32'h0, NOP, 1'b0, 1'b1, 1'b0, 1'b0, NONE, 32'd0, 32'd0));
        tbl.push_back(mk(1'b0, 32'h0, NOP, 1'b0, 1'b1, 1'b0, 1'b0, NONE, 32'd0, 32'd0));
        tbl.push_back(mk(1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b1, 1'b0, NONE, 32'd0, 32'd0));

        foreach (tbl[n]) begin
            drive(tbl[n].r, tbl[n].p, tbl[n].i, tbl[n].v);
            tick();
            check($sformatf("vec%0d", n), tbl[n].e_cr, tbl[n].e_run, tbl[n].e_done,
                  tbl[n].e_st, tbl[n].e_cyc, tbl[n].e_ins);
        end

        // Stall: pc 0, 4, then 0x100 held from cycle 3; 16th repeat is cycle 19.
        for (int k = 1; k <= 19; k++) begin
            p = (k == 1) ? 32'h0 : (k == 2) ? 32'h4 : 32'h100;
            drive(1'b0, p, NOP, 1'b1);
            tick();
            if (k == 18) check_run("stall_pre", 32'd18, 32'd18);
            if (k == 19) check_done("stall_hit", STALL, 32'd19, 32'd19);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h200 + 32'(4 * k), ECALL, 1'b1);
            tick();
            check_done($sformatf("stall_frozen%0d", k), STALL, 32'd19, 32'd19);
        end

        // Timeout: pc advancing, valid on odd cycles only, ecall while not valid.
        restart_to_run("to");
        for (int k = 1; k <= 50; k++) begin
            drive(1'b0, 32'h2000 + 32'(4 * k), (k[0] ? NOP : ECALL), k[0]);
            tick();
            if (k == 49) check_run("timeout_pre", 32'd49, 32'd25);
            if (k == 50) check_done("timeout_hit", TIMEOUT, 32'd50, 32'd25);
        end

        // Ecall coinciding with the stall threshold and the last budget cycle.
        restart_to_run("prio");
        for (int k = 1; k <= 50; k++) begin
            p = (k < 20) ? (32'h3000 + 32'(4 * k)) : (k < 34) ? 32'h200 : 32'h300;
            drive(1'b0, p, (k == 50) ? ECALL : NOP, 1'b1);
            tick();
            if (k == 49) check_run("prio_pre", 32'd49, 32'd49);
            if (k == 50) check_done("prio_hit", HALT, 32'd50, 32'd50);
        end

        // Restart, run six cycles, then assert reset in the middle of cycle 7.
        restart_to_run("ar");
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 32'h4000 + 32'(4 * k), NOP, 1'b1);
            tick();
        end
        check_run("ar_pre", 32'd6, 32'd6);
        drive(1'b0, 32'h4100, NOP, 1'b1);
        #3 reset = 1'b0;
        #1;
        check_hold("ar_async");
        tick();
        check_hold("ar_held");
        reset = 1'b1;
        tick();
        check_hold("ar_rel1");
        tick();
        check_run("ar_rel2", 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tb_run_ctrl.md
TB_RUN_CTRL -- requirements
Module: tb_run_ctrl

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 32, PC width.
REQ-002 The block SHALL have parameter DWIDTH, default 32, instruction width.
REQ-003 The block SHALL have parameter RESET_CYCLES, default 2, core reset hold length in clocks (legal range >=1).
REQ-004 The block SHALL have parameter MAX_CYCLES, default 1000, run-phase cycle budget (legal range >=2).
REQ-005 The block SHALL have parameter STALL_LIMIT, default 16, consecutive unchanged-PC cycles that declare a stall (legal range >=2).
REQ-006 The block SHALL have parameter CWIDTH, default 32, counter width (legal range >= $clog2(MAX_CYCLES+1)).
REQ-007 The block SHALL have port clk, input, 1 bit, sole clock; all state on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-009 The block SHALL have port restart, input, 1 bit, single-cycle request for a new run.
REQ-010 The block SHALL have port pc, input, AWIDTH bits, DUT fetch PC.
REQ-011 The block SHALL have port insn, input, DWIDTH bits, DUT fetched instruction.
REQ-012 The block SHALL have port insn_valid, input, 1 bit, insn is valid this cycle.
REQ-013 The block SHALL have port core_reset, output, 1 bit, active-high reset driven to the DUT.
REQ-014 The block SHALL have port running, output, 1 bit, high in RUN state.
REQ-015 The block SHALL have port done, output, 1 bit, high in DONE state.
REQ-016 The block SHALL have port status, output, 2 bits, 0 none, 1 halt, 2 timeout, 3 stall.
REQ-017 The block SHALL have ports cycle_count and insn_count, outputs, CWIDTH bits each, run-phase cycles and valid instructions.

Function
REQ-018 The FSM SHALL have exactly three states: HOLD, RUN and DONE.
REQ-019 In HOLD, the block SHALL drive core_reset=1 and count clocks; it SHALL enter RUN on the edge ending the RESET_CYCLES-th HOLD cycle.
REQ-020 In RUN, core_reset SHALL be 0, cycle_count SHALL increment by 1 per clock, and insn_count SHALL increment by 1 per clock with insn_valid=1.
REQ-021 Halt: in RUN, insn_valid=1 with insn==HALT_INSN SHALL move the FSM to DONE with status=1 on the next edge; the halting instruction SHALL be counted.
REQ-022 Stall: in RUN, when pc equals the previous cycle's pc on STALL_LIMIT consecutive cycles, the FSM SHALL move to DONE with status=3; any pc change SHALL clear the run-length count.
REQ-023 The first RUN cycle SHALL have no previous pc and SHALL not count toward a stall.
REQ-024 Timeout: when cycle_count reaches MAX_CYCLES-1 in RUN, the next edge SHALL move the FSM to DONE with status=2 and cycle_count=MAX_CYCLES.
REQ-025 When several terminating conditions occur in the same cycle, priority SHALL be halt > stall > timeout.
REQ-026 In DONE, done=1, core_reset=1, and status and both counters SHALL be frozen.
REQ-027 restart=1 in DONE SHALL move the FSM to HOLD on the next edge and clear status, both counters and stall state.
REQ-028 restart SHALL be ignored in HOLD and RUN.
REQ-029 insn and insn_valid SHALL be ignored outside RUN.
REQ-030 Counters SHALL never wrap, because the CWIDTH rule guarantees this.
REQ-031 All outputs SHALL be registered or decoded from state only, with no combinational path from any input.

Reset
REQ-032 Assertion of reset at any time, including mid-run, SHALL asynchronously force HOLD with the hold counter at 0, core_reset=1, running=0, done=0, status=0, cycle_count=0, insn_count=0 and the stall count at 0.
REQ-033 Deassertion of reset SHALL be followed by exactly RESET_CYCLES clocks of core_reset=1.

Structure
REQ-034 Package tb_run_pkg SHALL hold the state enum, the status enum (NONE, HALT, TIMEOUT, STALL) and HALT_INSN = 32'h0000_0073 (ecall).
REQ-035 One sub-module, stall_detector, SHALL hold the previous pc register and the run-length counter, with parameters AWIDTH and STALL_LIMIT and a single stall output.

Verification
REQ-036 The bench SHALL cover this scenario: RESET_CYCLES=2, release reset -> core_reset high for exactly 2 rising edges, then running=1 and cycle_count=0.
REQ-037 The bench SHALL cover this scenario: pc incrementing by 4, insn_valid=1, ecall on the 10th run cycle -> done=1, status=1, insn_count=10, cycle_count=10.
REQ-038 The bench SHALL cover this scenario: pc held at 0x0000_0100 from run cycle 3 with STALL_LIMIT=16 -> status=3 after the 16th repeat, counters frozen.
REQ-039 The bench SHALL cover this scenario: MAX_CYCLES=50, no halt, pc advancing -> status=2, cycle_count=50, done=1.
REQ-040 The bench SHALL cover this scenario: ecall in the same cycle as the stall threshold and as MAX_CYCLES-1 -> status=1.
REQ-041 The bench SHALL cover this scenario: restart pulse in DONE, then reset asserted mid-RUN at cycle 7 -> counters 0, state HOLD, core_reset=1 immediately (asynchronous).
